// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// ----------------------
// Sequences one shared, external, combinational 4-bit adder slice to add two
// 4*NIBBLES-bit operands one nibble per cycle, least-significant nibble first.
// The ripple carry between nibbles is held in a flop. The result is exactly
// what the attached slice produces; no correction is applied here, so an
// approximate slice can be swapped in for accuracy studies.
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   : adds input in_sub (sampled at accept). in_sub=1 computes A-B
//               mod 2^DW by feeding ~B nibbles with an initial carry of 1;
//               out_cout=1 then means "no borrow" (A >= B unsigned).
//   undefined : add only, initial carry 0, no in_sub port.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a/in_b are the operands
//   in_sub              (SERIAL_SUB_EN only) subtract select
//   out_valid/out_ready result handshake; out_sum/out_cout are registered
//   sl_a/sl_b/sl_cin    drive the external slice (zero outside RUN)
//   sl_sum/sl_cout      slice results, used only in RUN
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_valid, out_sum and out_cout hold steady until the sink takes
// the result. in_ready is high in IDLE, and in DONE while out_ready is high so
// a new operand pair can be taken on the same edge the result leaves.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
`ifdef SERIAL_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic [3:0]             sl_a,
    output logic [3:0]             sl_b,
    output logic                   sl_cin,
    input  logic [3:0]             sl_sum,
    input  logic                   sl_cout
);

    localparam int DW = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   a_sh;
    logic [DW-1:0]   b_sh;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;
    logic            sub_r;
    logic            init_cin;
    logic [DW-1:0]   sum_next;

`ifdef SERIAL_SUB_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= in_sub;
        end
    end
    // Two's-complement subtract: A + ~B + 1, the +1 entering as initial carry.
    assign init_cin = in_sub;
`else
    assign sub_r    = 1'b0;
    assign init_cin = 1'b0;
`endif

    assign accept = in_valid & in_ready;
    assign last   = (idx == IW'(NIBBLES - 1));

    // New slice nibble enters at the MSB end; after NIBBLES shifts the first
    // (least significant) nibble has reached bit 0. Written with shifts so
    // that NIBBLES=1 needs no special case.
    assign sum_next = (out_sum >> 4) | (DW'(sl_sum) << (DW - 4));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        sl_a       = 4'd0;
        sl_b       = 4'd0;
        sl_cin     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                sl_a   = a_sh[3:0];
                sl_b   = sub_r ? ~b_sh[3:0] : b_sh[3:0];
                sl_cin = carry;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh      <= in_a;
                b_sh      <= in_b;
                carry     <= init_cin;
                idx       <= '0;
                out_valid <= 1'b0;
            end else if (state == RUN) begin
                out_sum <= sum_next;
                a_sh    <= a_sh >> 4;
                b_sh    <= b_sh >> 4;
                carry   <= sl_cout;
                idx     <= idx + IW'(1);
                if (last) begin
                    out_cout  <= sl_cout;
                    out_valid <= 1'b1;
                end
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
// -------------------------
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=8) with an exact
// 4-bit slice modelled combinationally. Expected results come from plain
// wide arithmetic on the whole operands. A driver task pushes expectations
// into exp_q at accept; a monitor pops and compares whenever a result is
// transferred. Honours SERIAL_SUB_EN the same way as the design.
module tb_nibble_serial_add_ctrl;

    localparam int N  = 8;
    localparam int DW = 4 * N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
`ifdef SERIAL_SUB_EN
    logic            in_sub = 1'b0;
`endif
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_sum;
    logic            out_cout;
    logic [3:0]      sl_a;
    logic [3:0]      sl_b;
    logic            sl_cin;
    logic [3:0]      sl_sum;
    logic            sl_cout;

    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    logic [DW:0]     exp_q[$];
    int              acc_q[$];
    int              rise_q[$];
    logic            prev_valid = 1'b0;
    logic            rand_ready = 1'b0;
    logic            ready_cmd = 1'b1;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef SERIAL_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .sl_a      (sl_a),
        .sl_b      (sl_b),
        .sl_cin    (sl_cin),
        .sl_sum    (sl_sum),
        .sl_cout   (sl_cout)
    );

    // Exact slice.
    assign {sl_cout, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {4'd0, sl_cin};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sole driver of out_ready: random during the soak phase, else commanded.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic; bit DW is the carry out.
    function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        return {1'b0, a} + {1'b0, b};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        in_a     = a;
        in_b     = b;
`ifdef SERIAL_SUB_EN
        in_sub   = sub;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(a, b, sub));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                rise_q.push_back(cyc);
                if (acc_q.size() != 0) begin
                    check("latency", 64'(cyc - acc_q.pop_front()), 64'(N));
                end else begin
                    check("spurious_valid", 64'(out_valid), 64'd0);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    check("result", 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
                end else begin
                    check("spurious_result", 64'(out_valid), 64'd0);
                end
            end
        end
        prev_valid = out_valid;
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          s;
        int            k;

        // Reset held two cycles.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full carry ripple: FFFFFFFF + 1.
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        send(a, b, 1'b0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("ripple_sl_cin", 64'(sl_cin), (i == 0) ? 64'd0 : 64'd1);
            check("ripple_sl_a", 64'(sl_a), 64'(a[4*i +: 4]));
            check("ripple_sl_b", 64'(sl_b), 64'(b[4*i +: 4]));
            check("ripple_in_ready", 64'(in_ready), 64'd0);
        end
        drain();
        check("ripple_sum", 64'(out_sum), 64'h0);
        check("ripple_cout", 64'(out_cout), 64'd1);

        // Back-pressure: result must hold while the sink stalls.
        ready_cmd = 1'b0;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(out_sum), 64'hACF1_3568);
            check("stall_cout", 64'(out_cout), 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        ready_cmd = 1'b1;
        drain();
        @(negedge clk);
        check("stall_idle_valid", 64'(out_valid), 64'd0);
        check("stall_idle_ready", 64'(in_ready), 64'd1);

        // Back-to-back: three pairs, results every N+1 cycles.
        rise_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(DW'($urandom), DW'($urandom), 1'b0);
        end
        drain();
        check("b2b_count", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            check("b2b_gap1", 64'(rise_q[1] - rise_q[0]), 64'(N + 1));
            check("b2b_gap2", 64'(rise_q[2] - rise_q[1]), 64'(N + 1));
        end

        // Reset in the middle of RUN (nibble index 4) aborts the add.
        send(DW'($urandom), DW'($urandom), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_sum", 64'(out_sum), 64'd0);
        send(32'h1, 32'h1, 1'b0);
        drain();
        check("abort_new_sum", 64'(out_sum), 64'h2);

`ifdef SERIAL_SUB_EN
        send(32'h5, 32'h7, 1'b1);
        drain();
        check("sub_5_7_sum", 64'(out_sum), 64'hFFFF_FFFE);
        check("sub_5_7_cout", 64'(out_cout), 64'd0);
        send(32'h7, 32'h5, 1'b1);
        drain();
        check("sub_7_5_sum", 64'(out_sum), 64'h2);
        check("sub_7_5_cout", 64'(out_cout), 64'd1);
`endif

        // Randomized soak with random sink back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = '1;
                default: a = DW'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
`ifdef SERIAL_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            send(a, b, s);
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
